ram_16k: RTL and testbench



---
 rtl/ram_16k_pkg.sv | 10 +
 rtl/ram_16k_ram4k.sv | 29 ++
 rtl/ram_16k.sv | 38 +++
 tb/tb_ram_16k.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ram_16k_pkg.sv
// Shared sizing for the 16K-word data RAM and its 4K banks.
package ram_16k_pkg;
  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 14;
  localparam int DEPTH       = 16384;
  localparam int BANK_ADDR_W = 12;
  localparam int NUM_BANKS   = 4;
  localparam int BANK_SEL_W  = ADDR_W - BANK_ADDR_W;
  localparam int BANK_DEPTH  = DEPTH / NUM_BANKS;
endpackage

// File: rtl/ram_16k_ram4k.sv
// 4K x 16 bank: combinational read, clocked write, synchronous clear of every word.
module ram4k
  import ram_16k_pkg::*;
(
  output logic [DATA_W-1:0]      out,
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [BANK_ADDR_W-1:0] address,
  input  logic [DATA_W-1:0]      in
);

  logic [DATA_W-1:0] mem_q [BANK_DEPTH];
  logic              wr_en;

  // Reset wins over a same-edge write.
  always_comb wr_en = load && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BANK_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[address] <= in;
    end
  end

  assign out = mem_q[address];

endmodule

// File: rtl/ram_16k.sv
// 16K x 16 data RAM built from four 4K banks selected by the two address MSBs.
module ram_16k
  import ram_16k_pkg::*;
(
  output logic [DATA_W-1:0] out,
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in
);

  logic [BANK_SEL_W-1:0]               bank_sel;
  logic [NUM_BANKS-1:0]                bank_load;
  logic [NUM_BANKS-1:0][DATA_W-1:0]    bank_out;

  assign bank_sel = address[ADDR_W-1 -: BANK_SEL_W];

  always_comb begin
    bank_load = '0;
    bank_load[bank_sel] = load;
  end

  // Reset fans out to every bank; only the selected bank sees load.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ram4k u_bank (
      .out     (bank_out[b]),
      .clk     (clk),
      .reset   (reset),
      .load    (bank_load[b]),
      .address (address[BANK_ADDR_W-1:0]),
      .in      (in)
    );
  end

  assign out = bank_out[bank_sel];

endmodule

// File: tb/tb_ram_16k.sv
// Scoreboard bench for ram_16k: stimulus queues expected reads, monitor compares at negedge.
module tb_ram_16k;
  timeunit 1ns;
  timeprecision 100ps;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [13:0] address = '0;
  logic [15:0] din = '0;
  logic [15:0] out;
  logic        rd_vld = 1'b0;

  typedef struct {
    logic [13:0] addr;
    logic [15:0] exp;
  } rd_t;

  rd_t         sb_q[$];
  logic [15:0] model [16384];
  int          checks = 0;
  int          errors = 0;

  ram_16k dut (
    .out     (out),
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .address (address),
    .in      (din)
  );

  always #5 clk = ~clk;

  // One cycle: drive just after posedge, optionally queue a read of the
  // pre-edge contents, then advance the model by what the next edge does.
  task automatic cyc(input logic rst, input logic ld, input logic [13:0] a,
                     input logic [15:0] d, input logic chk);
    @(posedge clk);
    #1;
    reset   = rst;
    load    = ld;
    address = a;
    din     = d;
    rd_vld  = chk;
    if (chk) sb_q.push_back('{addr: a, exp: model[a]});
    if (rst) begin
      for (int i = 0; i < 16384; i++) model[i] = 16'h0000;
    end else if (ld) begin
      model[a] = d;
    end
  endtask

  task automatic rd(input logic [13:0] a);
    cyc(1'b0, 1'b0, a, 16'($urandom), 1'b1);
  endtask

  task automatic wr(input logic [13:0] a, input logic [15:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rd_vld) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected addr=%h got=%h", address, out);
      end else begin
        rd_t e;
        e = sb_q.pop_front();
        if (out !== e.exp || address !== e.addr) begin
          errors++;
          $display("FAIL rd addr=%h got=%h exp=%h", e.addr, out, e.exp);
        end
      end
    end
  end

  initial begin
    // Reset then sweep
    cyc(1'b1, 1'b0, 14'd0, 16'h0, 1'b0);
    rd(14'd0); rd(14'd1); rd(14'd4095); rd(14'd4096); rd(14'd16383);

    // Basic write/read
    wr(14'd5, 16'h1234);
    rd(14'd5); rd(14'd6);

    // Hold with load=0
    wr(14'd3, 16'h0001);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 14'd3, 16'h0002, 1'b1);

    // Bank isolation
    wr(14'd0, 16'hAAAA); wr(14'd4096, 16'hBBBB);
    wr(14'd8192, 16'hCCCC); wr(14'd16383, 16'hDDDD);
    rd(14'd0); rd(14'd4096); rd(14'd8192); rd(14'd16383);
    rd(14'd4095); rd(14'd12288);

    // Read-during-write: old value before the edge, new value after it
    cyc(1'b0, 1'b1, 14'd9000, 16'h5A5A, 1'b1);
    rd(14'd9000);

    // Streaming: addr mod 20 per cycle, data every 2 cycles, load every 4
    for (int k = 0; k < 120; k++)
      cyc(1'b0, ((k / 4) % 2) == 0, 14'(k % 20), 16'h0100 + 16'(k / 2), 1'b1);
    for (int k = 0; k < 20; k++) rd(14'(k));

    // Randomized traffic over a small window in each bank
    for (int k = 0; k < 400; k++) begin
      logic [13:0] a;
      a = {2'($urandom_range(0, 3)), 12'($urandom_range(0, 15))};
      cyc(1'b0, $urandom_range(0, 1) == 1, a, 16'($urandom), 1'b1);
    end

    // Reset priority over a same-edge write
    wr(14'd7, 16'h0777);
    cyc(1'b1, 1'b1, 14'd7, 16'hFFFF, 1'b1);
    rd(14'd7); rd(14'd5); rd(14'd3); rd(14'd0); rd(14'd4096); rd(14'd16383);

    // Post-reset random writes still work
    for (int k = 0; k < 60; k++) begin
      logic [13:0] a;
      a = 14'($urandom_range(0, 7)) << 11;
      cyc(1'b0, $urandom_range(0, 1) == 1, a, 16'($urandom), 1'b1);
    end

    @(posedge clk);
    #1;
    rd_vld = 1'b0;
    load   = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
